// File: rtl/pipelined_rca_addsub_if.sv
// rtl/pipelined_rca_addsub_if.sv - operand/result handshake bundle for pipelined_rca_addsub
interface pipelined_rca_addsub_if #(
  parameter int N = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] sum;
  logic         cout;
  logic         overflow;
  logic         zero;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, overflow, zero
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, overflow, zero
  );
endinterface

// File: rtl/pipelined_rca_addsub.sv
// rtl/pipelined_rca_addsub.sv - ripple-carry add/sub with one carry-chain slice resolved per stage
// Optional overflow/zero flags are built only when ADDSUB_FLAGS_EN is defined.
module pipelined_rca_addsub #(
  parameter int N      = 32,
  parameter int STAGES = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  pipelined_rca_addsub_if.slave        bus
);
  localparam int W = N / STAGES;

  logic [STAGES-1:0][N-1:0] a_d, a_q;
  logic [STAGES-1:0][N-1:0] b_d, b_q;
  logic [STAGES-1:0][N-1:0] s_d, s_q;
  logic [STAGES-1:0]        c_d, c_q;
  logic [STAGES-1:0]        v_d, v_q;

  logic         adv;
  logic         accept;
  logic [N-1:0] b_eff;
  logic         c0;
  logic [W:0]   slice;

  // The whole pipe moves as one shift register; bubbles are never squeezed out.
  assign adv          = !v_q[STAGES-1] || bus.out_ready;
  assign accept       = bus.in_valid && adv;
  assign bus.in_ready = adv;

  assign b_eff = bus.sub ? ~bus.b : bus.b;
  assign c0    = bus.sub | bus.cin;

  always_comb begin
    a_d   = '0;
    b_d   = '0;
    s_d   = '0;
    c_d   = '0;
    v_d   = '0;
    slice = '0;

    a_d[0] = bus.a;
    b_d[0] = b_eff;
    v_d[0] = accept;
    slice  = {1'b0, bus.a[W-1:0]} + {1'b0, b_eff[W-1:0]} + {{W{1'b0}}, c0};
    s_d[0][W-1:0] = slice[W-1:0];
    c_d[0]        = slice[W];

    // Stage k adds slice k from the operands and carry left behind by stage k-1.
    for (int k = 1; k < STAGES; k++) begin
      a_d[k] = a_q[k-1];
      b_d[k] = b_q[k-1];
      v_d[k] = v_q[k-1];
      slice  = {1'b0, a_q[k-1][k*W +: W]} + {1'b0, b_q[k-1][k*W +: W]}
             + {{W{1'b0}}, c_q[k-1]};
      s_d[k]            = s_q[k-1];
      s_d[k][k*W +: W]  = slice[W-1:0];
      c_d[k]            = slice[W];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_q <= '0;
      b_q <= '0;
      s_q <= '0;
      c_q <= '0;
      v_q <= '0;
    end else if (adv) begin
      a_q <= a_d;
      b_q <= b_d;
      s_q <= s_d;
      c_q <= c_d;
      v_q <= v_d;
    end
  end

  assign bus.out_valid = v_q[STAGES-1];
  assign bus.sum       = s_q[STAGES-1];
  assign bus.cout      = c_q[STAGES-1];

  // Operand bits already consumed by earlier slices are dropped by synthesis.
  logic unused_operands;
  assign unused_operands = ^{a_q, b_q};

`ifdef ADDSUB_FLAGS_EN
  logic ovf_d, ovf_q;
  logic zero_d, zero_q;

  assign ovf_d  = (a_d[STAGES-1][N-1] == b_d[STAGES-1][N-1])
               && (s_d[STAGES-1][N-1] != a_d[STAGES-1][N-1]);
  assign zero_d = (s_d[STAGES-1] == '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (adv) begin
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end

  assign bus.overflow = ovf_q;
  assign bus.zero     = zero_q;
`else
  assign bus.overflow = 1'b0;
  assign bus.zero     = 1'b0;
`endif
endmodule

// File: tb/tb_pipelined_rca_addsub.sv
// tb/tb_pipelined_rca_addsub.sv - directed vector bench for pipelined_rca_addsub at STAGES 1, 4 and 32
module tb_pipelined_rca_addsub;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        t_iv, t_cin, t_sub, t_ordy;
  logic [31:0] t_a, t_b;

  int checks = 0;
  int errors = 0;

`ifdef ADDSUB_FLAGS_EN
  localparam bit FLAGS_ON = 1'b1;
`else
  localparam bit FLAGS_ON = 1'b0;
`endif

  pipelined_rca_addsub_if #(.N(32)) if1 ();
  pipelined_rca_addsub_if #(.N(32)) if4 ();
  pipelined_rca_addsub_if #(.N(32)) if32 ();

  assign if1.in_valid  = t_iv;  assign if1.a  = t_a; assign if1.b  = t_b;
  assign if1.cin       = t_cin; assign if1.sub = t_sub; assign if1.out_ready = t_ordy;
  assign if4.in_valid  = t_iv;  assign if4.a  = t_a; assign if4.b  = t_b;
  assign if4.cin       = t_cin; assign if4.sub = t_sub; assign if4.out_ready = t_ordy;
  assign if32.in_valid = t_iv;  assign if32.a = t_a; assign if32.b = t_b;
  assign if32.cin      = t_cin; assign if32.sub = t_sub; assign if32.out_ready = t_ordy;

  pipelined_rca_addsub #(.N(32), .STAGES(1))  u1  (.clk_i(clk), .rst_ni(rst_n), .bus(if1.slave));
  pipelined_rca_addsub #(.N(32), .STAGES(4))  u4  (.clk_i(clk), .rst_ni(rst_n), .bus(if4.slave));
  pipelined_rca_addsub #(.N(32), .STAGES(32)) u32 (.clk_i(clk), .rst_ni(rst_n), .bus(if32.slave));

  typedef struct packed {
    logic        v;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
    logic        rdy;
  } obs_t;

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } res_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } vec_t;

  vec_t vt[12];

  function automatic logic fl(input logic x);
    return x & FLAGS_ON;
  endfunction

  function automatic obs_t obs(input int d);
    case (d)
      0:       obs = {if1.out_valid, if1.sum, if1.cout, if1.overflow, if1.zero, if1.in_ready};
      1:       obs = {if4.out_valid, if4.sum, if4.cout, if4.overflow, if4.zero, if4.in_ready};
      2:       obs = {if32.out_valid, if32.sum, if32.cout, if32.overflow, if32.zero, if32.in_ready};
      default: obs = '0;
    endcase
  endfunction

  function automatic res_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic cin, input logic sub);
    logic [32:0] r;
    res_t m;
    if (sub) begin
      r      = {1'b0, a} - {1'b0, b};
      m.sum  = r[31:0];
      m.cout = !r[32];
      m.ovf  = fl((a[31] != b[31]) && (m.sum[31] != a[31]));
    end else begin
      r      = {1'b0, a} + {1'b0, b} + {32'b0, cin};
      m.sum  = r[31:0];
      m.cout = r[32];
      m.ovf  = fl((a[31] == b[31]) && (m.sum[31] != a[31]));
    end
    m.zero = fl(m.sum == 32'h0);
    return m;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    obs_t o;
    obs_t got[3];
    int   lat[3];
    int   expl[3];
    expl = '{1, 4, 32};
    lat  = '{0, 0, 0};
    @(negedge clk);
    t_a = v.a; t_b = v.b; t_cin = v.cin; t_sub = v.sub; t_iv = 1'b1; t_ordy = 1'b1;
    @(negedge clk);
    t_iv = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      for (int d = 0; d < 3; d++) begin
        o = obs(d);
        if (o.v && lat[d] == 0) begin
          lat[d] = c;
          got[d] = o;
        end
      end
      @(negedge clk);
    end
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("vec%0d_s%0d_latency", idx, expl[d]), 64'(lat[d]), 64'(expl[d]));
      if (lat[d] != 0) begin
        chk($sformatf("vec%0d_s%0d_sum", idx, expl[d]),  64'(got[d].sum),  64'(v.sum));
        chk($sformatf("vec%0d_s%0d_cout", idx, expl[d]), 64'(got[d].cout), 64'(v.cout));
        chk($sformatf("vec%0d_s%0d_ovf", idx, expl[d]),  64'(got[d].ovf),  64'(v.ovf));
        chk($sformatf("vec%0d_s%0d_zero", idx, expl[d]), 64'(got[d].zero), 64'(v.zero));
      end
    end
  endtask

  // Streams n random beats through the STAGES=4 instance, optionally with a 1,0,0,1 out_ready pattern.
  task automatic stream(input int n, input bit bp, input string tag);
    res_t q[$];
    res_t e;
    obs_t o, held;
    bit   stalled = 1'b0;
    bit   pend = 1'b0;
    bit   pat[4];
    int   sent = 0, got = 0, first = -1, last = -1;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    held = '0;
    for (int cyc = 0; cyc < 2000 && got < n; cyc++) begin
      @(negedge clk);
      t_ordy = bp ? pat[cyc % 4] : 1'b1;
      if (!pend && sent < n) begin
        t_a   = $urandom;
        t_b   = $urandom;
        t_cin = 1'($urandom_range(0, 1));
        t_sub = 1'($urandom_range(0, 1));
        pend  = 1'b1;
      end
      t_iv = pend;
      #1;
      o = obs(1);
      chk({tag, "_in_ready"}, 64'(o.rdy), 64'(!o.v || t_ordy));
      if (stalled) begin
        chk({tag, "_hold_sum"},  64'(o.sum),  64'(held.sum));
        chk({tag, "_hold_cout"}, 64'(o.cout), 64'(held.cout));
        chk({tag, "_hold_v"},    64'(o.v),    64'(held.v));
      end
      if (o.v && t_ordy) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL %s_extra: actual unexpected result %0h required none", tag, o.sum);
        end else begin
          e = q.pop_front();
          chk({tag, "_sum"},  64'(o.sum),  64'(e.sum));
          chk({tag, "_cout"}, 64'(o.cout), 64'(e.cout));
          chk({tag, "_ovf"},  64'(o.ovf),  64'(e.ovf));
          chk({tag, "_zero"}, 64'(o.zero), 64'(e.zero));
        end
        got++;
        if (first < 0) first = cyc;
        last = cyc;
      end
      stalled = o.v && !t_ordy;
      held    = o;
      if (pend && o.rdy) begin
        q.push_back(model(t_a, t_b, t_cin, t_sub));
        pend = 1'b0;
        sent++;
      end
    end
    t_iv = 1'b0;
    chk({tag, "_count_out"}, 64'(got), 64'(n));
    chk({tag, "_count_in"},  64'(sent), 64'(n));
    chk({tag, "_leftover"},  64'(q.size()), 64'(0));
    if (!bp) chk({tag, "_consecutive"}, 64'(last - first), 64'(n - 1));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: actual no finish required finish");
    $fatal(1);
  end

  initial begin
    obs_t o;
    int   appear;

    vt[0]  = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, fl(1'b0), fl(1'b1)};
    vt[1]  = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, fl(1'b1), fl(1'b0)};
    vt[2]  = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, fl(1'b0), fl(1'b0)};
    vt[3]  = '{32'h1234_5678, 32'h0FED_CBA8, 1'b1, 1'b0, 32'h2222_2221, 1'b0, fl(1'b0), fl(1'b0)};
    vt[4]  = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, fl(1'b1), fl(1'b0)};
    vt[5]  = '{32'h0000_0003, 32'h0000_0003, 1'b0, 1'b1, 32'h0000_0000, 1'b1, fl(1'b0), fl(1'b1)};
    vt[6]  = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0001, 1'b0, fl(1'b0), fl(1'b0)};
    vt[7]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, fl(1'b0), fl(1'b0)};
    vt[8]  = '{32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0, fl(1'b0), fl(1'b0)};
    vt[9]  = '{32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0007, 1'b1, fl(1'b0), fl(1'b0)};
    vt[10] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, fl(1'b1), fl(1'b1)};
    vt[11] = '{32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, fl(1'b0), fl(1'b0)};

    rst_n = 1'b1; t_iv = 1'b0; t_a = '0; t_b = '0; t_cin = 1'b0; t_sub = 1'b0; t_ordy = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      o = obs(d);
      chk($sformatf("reset_valid_d%0d", d), 64'(o.v),    64'(0));
      chk($sformatf("reset_ready_d%0d", d), 64'(o.rdy),  64'(1));
      chk($sformatf("reset_sum_d%0d", d),   64'(o.sum),  64'(0));
      chk($sformatf("reset_cout_d%0d", d),  64'(o.cout), 64'(0));
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) run_vec(vt[i], i);

    // Three beats in flight, then an asynchronous reset pulse mid-cycle.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      t_a = 32'h1111_0000 + 32'(i); t_b = 32'h0000_0101; t_cin = 1'b0; t_sub = 1'b0;
      t_iv = 1'b1; t_ordy = 1'b1;
    end
    @(negedge clk);
    t_iv = 1'b0;
    o = obs(0);
    chk("midflight_s1_valid_before_reset", 64'(o.v), 64'(1));
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      o = obs(d);
      chk($sformatf("midflight_valid_d%0d", d), 64'(o.v),    64'(0));
      chk($sformatf("midflight_sum_d%0d", d),   64'(o.sum),  64'(0));
      chk($sformatf("midflight_cout_d%0d", d),  64'(o.cout), 64'(0));
      chk($sformatf("midflight_ovf_d%0d", d),   64'(o.ovf),  64'(0));
      chk($sformatf("midflight_zero_d%0d", d),  64'(o.zero), 64'(0));
      chk($sformatf("midflight_ready_d%0d", d), 64'(o.rdy),  64'(1));
    end
    @(negedge clk);
    rst_n = 1'b1;
    appear = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        o = obs(d);
        if (o.v) appear++;
      end
    end
    chk("midflight_ghost_results", 64'(appear), 64'(0));

    stream(16, 1'b0, "stream");
    repeat (40) @(negedge clk);
    stream(12, 1'b1, "backpressure");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
